// File: rtl/acc_simd_pkg.sv
// Shared parameters and state encoding for the lane-parallel SIMD accumulator.
// Widths derive from the multiplier stage's picture count and output data width.
`ifndef PICTURE_NUM
`define PICTURE_NUM 8
`endif
`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 10
`endif

package acc_simd_pkg;

  localparam int DEF_LANES  = `PICTURE_NUM;
  localparam int DEF_PROD_W = 2 * `WIDTH_DATA_OUT;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_TAP_W  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/acc_fifo2.sv
// Two-entry synchronous FIFO holding completed lane-sum groups with their saturation flags.
// Pushes that arrive while full are ignored unless a pop happens in the same cycle.
module acc_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign do_pop_s  = pop && (count_r != 2'd0);
  assign do_push_s = push && ((count_r != 2'd2) || do_pop_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign valid = (count_r != 2'd0);
  assign count = count_r;

endmodule

// File: rtl/acc_simd.sv
// Lane-parallel saturating accumulator over a programmable tap window, feeding a
// 2-deep result FIFO with a valid/ready handshake toward writeback.
module acc_simd
  import acc_simd_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int TAP_W  = DEF_TAP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TAP_W-1:0]        tap_num,
  input  logic                    acc_clr,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  input  logic [LANES*PROD_W-1:0] prod_data,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic [LANES*ACC_W-1:0]  acc_data,
  output logic [LANES-1:0]        acc_sat
);

  localparam int FIFO_W = LANES * (ACC_W + 1);
  localparam logic [TAP_W-1:0] TAP_ONE = {{(TAP_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_e                 state_r;
  logic [TAP_W-1:0]       taps_r;
  logic [TAP_W-1:0]       tap_cnt_r;
  logic [LANES*ACC_W-1:0] acc_r;
  logic [LANES-1:0]       sat_r;
  logic                   prod_ready_r;

  logic                   first_s;
  logic                   beat_s;
  logic                   done_s;
  logic                   push_s;
  logic                   pop_s;
  logic [TAP_W-1:0]       tap_eff_s;
  logic [TAP_W-1:0]       taps_s;
  logic [TAP_W-1:0]       cnt_next_s;
  logic [LANES*ACC_W-1:0] sum_s;
  logic [LANES-1:0]       sat_s;
  logic [1:0]             fifo_count_s;
  logic [1:0]             count_next_s;
  logic                   fifo_valid_s;
  logic [FIFO_W-1:0]      fifo_dout_s;

  // The first beat of a group starts from zero and takes its tap count from tap_num.
  assign first_s    = (state_r == ST_IDLE);
  assign beat_s     = prod_valid && prod_ready_r;
  assign tap_eff_s  = (tap_num == {TAP_W{1'b0}}) ? TAP_ONE : tap_num;
  assign taps_s     = first_s ? tap_eff_s : taps_r;
  assign cnt_next_s = first_s ? TAP_ONE : (tap_cnt_r + TAP_ONE);
  assign done_s     = (cnt_next_s == taps_s);
  assign push_s     = beat_s && !acc_clr && done_s;
  assign pop_s      = fifo_valid_s && acc_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ACC_W:0] prod_ext_s;
    logic [ACC_W:0] base_ext_s;
    logic [ACC_W:0] sum_ext_s;
    logic           ovf_s;

    assign prod_ext_s = {{(ACC_W+1-PROD_W){prod_data[(i+1)*PROD_W-1]}},
                         prod_data[i*PROD_W +: PROD_W]};
    assign base_ext_s = first_s ? {(ACC_W+1){1'b0}}
                                : {acc_r[(i+1)*ACC_W-1], acc_r[i*ACC_W +: ACC_W]};
    assign sum_ext_s  = base_ext_s + prod_ext_s;
    // One extra guard bit: overflow shows as disagreement of the top two bits.
    assign ovf_s      = sum_ext_s[ACC_W] ^ sum_ext_s[ACC_W-1];
    assign sum_s[i*ACC_W +: ACC_W] = ovf_s ? (sum_ext_s[ACC_W] ? SAT_MIN : SAT_MAX)
                                           : sum_ext_s[ACC_W-1:0];
    assign sat_s[i]   = ovf_s | (!first_s & sat_r[i]);
  end

  // Predicted FIFO occupancy after this edge, used to register prod_ready
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = fifo_count_s + 2'd1;
      2'b01:   count_next_s = fifo_count_s - 2'd1;
      default: count_next_s = fifo_count_s;
    endcase
  end

  // Group FSM: abort, first beat, accumulate, complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      taps_r       <= TAP_ONE;
      tap_cnt_r    <= {TAP_W{1'b0}};
      acc_r        <= {(LANES*ACC_W){1'b0}};
      sat_r        <= {LANES{1'b0}};
      prod_ready_r <= 1'b0;
    end else begin
      prod_ready_r <= (count_next_s < 2'd2);
      if (acc_clr || (beat_s && done_s)) begin
        state_r   <= ST_IDLE;
        tap_cnt_r <= {TAP_W{1'b0}};
        acc_r     <= {(LANES*ACC_W){1'b0}};
        sat_r     <= {LANES{1'b0}};
      end else if (beat_s) begin
        state_r   <= ST_ACC;
        taps_r    <= taps_s;
        tap_cnt_r <= cnt_next_s;
        acc_r     <= sum_s;
        sat_r     <= sat_s;
      end else begin
        state_r   <= state_r;
      end
    end
  end

  acc_fifo2 #(
    .W(FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({sat_s, sum_s}),
    .dout  (fifo_dout_s),
    .valid (fifo_valid_s),
    .count (fifo_count_s)
  );

  assign prod_ready = prod_ready_r;
  assign acc_valid  = fifo_valid_s;
  assign acc_data   = fifo_dout_s[LANES*ACC_W-1:0];
  assign acc_sat    = fifo_dout_s[FIFO_W-1 -: LANES];

endmodule

// File: tb/tb_acc_simd.sv
// Directed self-checking bench for acc_simd: basic group, signed mix, saturation,
// backpressure, abort and asynchronous reset scenarios.
module tb_acc_simd;
  import acc_simd_pkg::*;

  localparam int L  = DEF_LANES;
  localparam int PW = DEF_PROD_W;
  localparam int AW = DEF_ACC_W;
  localparam int TW = DEF_TAP_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [TW-1:0]   tap_num;
  logic            acc_clr;
  logic            prod_valid;
  logic            prod_ready;
  logic [L*PW-1:0] prod_data;
  logic            acc_valid;
  logic            acc_ready;
  logic [L*AW-1:0] acc_data;
  logic [L-1:0]    acc_sat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_simd dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tap_num    (tap_num),
    .acc_clr    (acc_clr),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .acc_sat    (acc_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int i);
    return {{(32-AW){1'b0}}, acc_data[i*AW +: AW]};
  endfunction

  function automatic logic [31:0] x24(input int v);
    logic [AW-1:0] t;
    t = v[AW-1:0];
    return {{(32-AW){1'b0}}, t};
  endfunction

  task automatic set_all(input int v);
    for (int i = 0; i < L; i++) prod_data[i*PW +: PW] = v[PW-1:0];
  endtask

  task automatic set_lane(input int i, input int v);
    prod_data[i*PW +: PW] = v[PW-1:0];
  endtask

  initial begin
    rst_n      = 1'b0;
    tap_num    = 8'd0;
    acc_clr    = 1'b0;
    prod_valid = 1'b0;
    prod_data  = {(L*PW){1'b0}};
    acc_ready  = 1'b1;
    repeat (2) tick();
    chk("rst_prod_ready", {31'd0, prod_ready}, 32'd0);
    chk("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
    chk("rst_acc_data_l0", lane(0), 32'd0);
    chk("rst_acc_sat", {24'd0, acc_sat}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_prod_ready", {31'd0, prod_ready}, 32'd1);

    // Basic group: 9 taps of +100
    tap_num = 8'd9;
    set_all(100);
    prod_valid = 1'b1;
    repeat (8) tick();
    chk("basic_not_early", {31'd0, acc_valid}, 32'd0);
    tick();
    prod_valid = 1'b0;
    chk("basic_valid", {31'd0, acc_valid}, 32'd1);
    chk("basic_l0", lane(0), x24(900));
    chk("basic_l7", lane(7), x24(900));
    chk("basic_sat", {24'd0, acc_sat}, 32'd0);
    tick();
    chk("basic_single", {31'd0, acc_valid}, 32'd0);

    // Signed mix
    tap_num = 8'd3;
    set_all(0);
    set_lane(1, 524287);
    set_lane(0, -524288);
    prod_valid = 1'b1;
    tick();
    set_lane(0, 1);
    repeat (2) tick();
    prod_valid = 1'b0;
    chk("mix_valid", {31'd0, acc_valid}, 32'd1);
    chk("mix_l0", lane(0), x24(-524286));
    chk("mix_l1", lane(1), x24(1572861));
    chk("mix_sat", {24'd0, acc_sat}, 32'd0);
    tick();

    // Saturation on lane 3, then a clean group
    tap_num = 8'd20;
    set_all(0);
    set_lane(3, 524287);
    prod_valid = 1'b1;
    repeat (20) tick();
    prod_valid = 1'b0;
    chk("sat_valid", {31'd0, acc_valid}, 32'd1);
    chk("sat_l3", lane(3), x24(8388607));
    chk("sat_l0", lane(0), 32'd0);
    chk("sat_flags", {24'd0, acc_sat}, 32'h0000_0008);
    tick();
    tap_num = 8'd1;
    set_lane(3, 5);
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    chk("sat_clear_l3", lane(3), x24(5));
    chk("sat_clear_flags", {24'd0, acc_sat}, 32'd0);
    tick();

    // Backpressure: 2 groups buffered, then prod_ready drops
    acc_ready = 1'b0;
    tap_num = 8'd1;
    set_all(11);
    prod_valid = 1'b1;
    chk("bp_ready0", {31'd0, prod_ready}, 32'd1);
    tick();
    set_all(22);
    chk("bp_ready1", {31'd0, prod_ready}, 32'd1);
    tick();
    set_all(33);
    chk("bp_full", {31'd0, prod_ready}, 32'd0);
    repeat (2) tick();
    chk("bp_still_full", {31'd0, prod_ready}, 32'd0);
    chk("bp_hold_l0", lane(0), x24(11));
    acc_ready = 1'b1;
    tick();
    chk("bp_pop1_l0", lane(0), x24(22));
    chk("bp_ready_again", {31'd0, prod_ready}, 32'd1);
    tick();
    set_all(44);
    chk("bp_pop2_l0", lane(0), x24(33));
    tick();
    prod_valid = 1'b0;
    chk("bp_pop3_l0", lane(0), x24(44));
    tick();
    chk("bp_drained", {31'd0, acc_valid}, 32'd0);

    // Abort mid-group, then a fresh 5-tap group of +2
    tap_num = 8'd5;
    set_all(7);
    prod_valid = 1'b1;
    repeat (3) tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("abort_no_out", {31'd0, acc_valid}, 32'd0);
    set_all(2);
    repeat (4) tick();
    chk("abort_not_early", {31'd0, acc_valid}, 32'd0);
    tick();
    prod_valid = 1'b0;
    chk("abort_valid", {31'd0, acc_valid}, 32'd1);
    chk("abort_l0", lane(0), x24(10));
    chk("abort_l5", lane(5), x24(10));
    tick();
    chk("abort_single", {31'd0, acc_valid}, 32'd0);

    // Asynchronous reset with one FIFO entry and a partial group
    acc_ready = 1'b0;
    tap_num = 8'd1;
    set_all(9);
    prod_valid = 1'b1;
    tick();
    tap_num = 8'd4;
    set_all(3);
    repeat (2) tick();
    prod_valid = 1'b0;
    chk("rst2_held", {31'd0, acc_valid}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst2_valid_drop", {31'd0, acc_valid}, 32'd0);
    chk("rst2_ready_drop", {31'd0, prod_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_ready = 1'b1;
    tick();
    chk("rst2_ready", {31'd0, prod_ready}, 32'd1);
    chk("rst2_no_stale", {31'd0, acc_valid}, 32'd0);
    tap_num = 8'd0;
    set_all(5);
    prod_valid = 1'b1;
    tick();
    prod_valid = 1'b0;
    chk("tap0_valid", {31'd0, acc_valid}, 32'd1);
    chk("tap0_l0", lane(0), x24(5));
    chk("tap0_l6", lane(6), x24(5));
    tick();
    chk("tap0_single", {31'd0, acc_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_simd.md
# acc_simd

Lane-parallel accumulator that consumes the packed product bus produced by the SIMD multiplier stage. Each lane's product is sign-extended and summed with saturation over a programmable number of taps (kernel window). Each completed group of sums is buffered in a 2-entry output FIFO and presented with a valid/ready handshake to the requantisation/writeback stage. It is the read side of the multiplier output interface: one product beat in, one multi-lane sum out per group.

## Interface

- LANES, default `PICTURE_NUM (8): parallel lanes, must be even.
- PROD_W, default 2*`WIDTH_DATA_OUT (20): signed product width per lane.
- ACC_W, default 24: signed accumulator width per lane; must be >= PROD_W.
- TAP_W, default 8: width of the tap-count field.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tap_num  in  TAP_W  products per group; sampled on the first beat of each group; 0 is treated as 1.
- acc_clr  in  1  synchronous abort; discards the partial group and leaves the FIFO intact.
- prod_valid  in  1  product beat present.
- prod_ready  out  1  beat accepted when prod_valid && prod_ready.
- prod_data  in  LANES*PROD_W  lane i occupies bits [(i+1)*PROD_W-1 : i*PROD_W].
- acc_valid  out  1  FIFO head valid.
- acc_ready  in  1  downstream accepts head.
- acc_data  out  LANES*ACC_W  lane sums, same lane ordering as prod_data.
- acc_sat  out  LANES  per-lane flag; high if saturation occurred at any point in the group.

## Operation

- State machine:
  - IDLE: no partial group.
  - ACC: partial group held; tap_cnt < taps.
- Transitions:
  - IDLE, accepted beat with taps==1: push acc_sat/acc_data to the FIFO, stay IDLE.
  - IDLE, accepted beat with taps>1: load the sign-extended product, latch taps = max(tap_num,1), set tap_cnt=1, go to ACC.
  - ACC, accepted beat: acc = sat(acc + sext(prod)) and tap_cnt++. When tap_cnt reaches taps, push the result, clear acc, and return to IDLE.
- Saturation: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. The per-lane sticky flag is ORed across the group and cleared when the group starts.
- prod_ready = (fifo_count < 2), registered-friendly; there is no combinational path from acc_ready.
- acc_clr has priority over a same-cycle beat. The beat is dropped, the state goes to IDLE, and acc and the flags are cleared. The FIFO and its outputs are unaffected.
- FIFO push and pop in the same cycle: count is unchanged and ordering is preserved. Pop occurs when acc_valid && acc_ready.
- tap_num changes mid-group are ignored until the next group starts.

## Timing

- Reset values: prod_ready=0 while rst_n low and 1 from the first cycle after deassertion; acc_valid=0; acc_data=0; acc_sat=0; state IDLE; FIFO empty.
- Latency: the final beat accepted at edge N gives acc_valid=1 with the sum after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle sustained while acc_ready is high. With acc_ready low, at most 2 groups are buffered, then prod_ready drops.
- acc_data and acc_sat are held stable while acc_valid && !acc_ready.
- Reset mid-group or with the FIFO full: all state is discarded immediately (asynchronous). No output is produced for the interrupted group.

## Structure

- Shared package holds LANES, PROD_W, ACC_W, TAP_W defaults (derived from `PICTURE_NUM and `WIDTH_DATA_OUT) and the state encoding (IDLE=0, ACC=1).
- One sub-module, acc_fifo2: a 2-deep synchronous FIFO, width LANES*(ACC_W+1), with count output.
- Top-level contents: lane generate loop (sign-extend, saturating add, sticky flag), tap counter, and FSM.

## Test plan

- Basic group: tap_num=9, all lanes = +100 for 9 consecutive beats. Expect one acc_valid at the cycle after beat 9, every lane = 900, acc_sat=0.
- Signed mix: tap_num=3, lane0 = -524288, +1, +1 and lane1 = 524287 ×3. Expect lane0 = -524286 and lane1 = 1572861, with no saturation.
- Saturation: tap_num=20, lane3 = +524287 each beat. Expect lane3 = 8388607 and acc_sat[3]=1, all other lanes' flags 0. The next group has the flag cleared.
- Backpressure: tap_num=1, acc_ready=0, 4 beats offered. Expect 2 accepted, then prod_ready=0. Raise acc_ready and expect the outputs in order, and prod_ready high again the cycle after the first pop.
- Abort: tap_num=5, 3 beats of +7, then acc_clr together with a beat, then 5 beats of +2. Expect a single output of 10 per lane.
- Reset: assert rst_n low mid-group with 1 FIFO entry held. acc_valid drops immediately. After release, a tap_num=0 beat of +5 yields 5 one cycle later.
